watch_ctrl: RTL and testbench
=============================

WATCH_CTRL -- requirements
Module: watch_ctrl

Interface
REQ-001 Parameter TICKS_PER_SEC, default 1000: tick_1khz pulses per second.
REQ-002 Parameter DEBOUNCE_TICKS, default 20: consecutive stable ticks needed to accept a key press.
REQ-003 CLOCK  in  1: sole clock; all logic on the negedge of CLOCK.
REQ-004 RESET  in  1: synchronous, active-high reset.
REQ-005 tick_1khz  in  1: one-CLOCK-cycle enable pulse at 1 kHz.
REQ-006 KEY_MODE, KEY_SET, KEY_INC  in  1 each: raw push-buttons, active-low, already synchronous to CLOCK.
REQ-007 mode  out  2: 0=RUN, 1=SET_HOUR, 2=SET_MIN, 3=STOPWATCH.
REQ-008 hour  out  5: time-of-day hours, 0..23.
REQ-009 minute, second  out  6 each: time-of-day, 0..59.
REQ-010 sw_min, sw_sec  out  6 each; sw_centi  out  7: stopwatch value, 0..59 / 0..59 / 0..99.
REQ-011 blink  out  1: display blank request for the field being edited.

Function
REQ-012 All state, counters and debouncers SHALL advance only in cycles with tick_1khz=1, except the 1-cycle press pulses and state register updates that follow them.
REQ-013 Debouncer per key: press pulse (1 CLOCK cycle) SHALL fire once when key is low for DEBOUNCE_TICKS consecutive ticks; no new pulse until key is high for DEBOUNCE_TICKS consecutive ticks.
REQ-014 ms counter 0..TICKS_PER_SEC-1 SHALL wrap to 0 and produce sec_pulse in the wrapping tick cycle.
REQ-015 Time of day SHALL advance on sec_pulse in RUN and STOPWATCH; 59 s -> 0 s carries minute; 59 min carries hour; 23:59:59 -> 00:00:00.
REQ-016 In SET_HOUR and SET_MIN, ms counter and second SHALL hold.
REQ-017 KEY_MODE press SHALL step RUN->SET_HOUR->SET_MIN->STOPWATCH->RUN, one cycle after the press pulse.
REQ-018 Leaving SET_MIN SHALL clear second and ms counter to 0.
REQ-019 KEY_INC press in SET_HOUR: hour+1 mod 24; in SET_MIN: minute+1 mod 60, no carry into hour.
REQ-020 KEY_SET press in STOPWATCH SHALL toggle sw_run; KEY_INC press in STOPWATCH with sw_run=0 SHALL clear sw_min/sw_sec/sw_centi; ignored when sw_run=1.
REQ-021 With sw_run=1, sw_centi SHALL increment every 10 ticks; 99->0 carries sw_sec; 59->0 carries sw_min; 59:59.99 wraps to 00:00.00.
REQ-022 Stopwatch SHALL keep counting when mode leaves STOPWATCH; sw_run retained.
REQ-023 KEY_SET/KEY_INC presses in modes without a defined action SHALL be ignored.
REQ-024 Simultaneous press pulses: KEY_MODE wins; other pulses in that cycle discarded.
REQ-025 blink SHALL be 1 when mode is SET_HOUR or SET_MIN and ms counter >= TICKS_PER_SEC/2, else 0.

Reset
REQ-026 RESET=1 at a CLOCK edge SHALL force mode=RUN, hour=minute=second=0, sw_*=0, sw_run=0, ms counter=0, blink=0, debouncers idle (keys treated as released).
REQ-027 RESET SHALL override all simultaneous ticks and presses, including mid-edit or mid-stopwatch-run.

Configuration
REQ-028 Macro WATCH_STOPWATCH_EN defined: STOPWATCH mode and REQ-020..022 present.
REQ-029 Macro undefined: mode cycles RUN->SET_HOUR->SET_MIN->RUN, mode never equals 3, sw_* outputs constant 0, KEY_SET unused.

Structure
REQ-030 Shared package SHALL hold mode encodings (RUN, SET_HOUR, SET_MIN, STOPWATCH) and limits 24, 60, 100, 10-tick centi prescale.
REQ-031 Sub-module key_debounce (one instance per key) SHALL implement REQ-013; watch_ctrl holds the FSM and counters.

Verification (TICKS_PER_SEC=10, DEBOUNCE_TICKS=3, tick_1khz=1 every cycle unless stated)
REQ-032 Reset then 10 ticks -> second=1; preload 23:59:59 via set flow, 10 ticks -> 00:00:00.
REQ-033 KEY_MODE low 2 ticks then high -> no mode change; low 3 ticks -> mode 0->1 exactly once, held low 20 ticks -> still 1.
REQ-034 mode=SET_HOUR, hour=23, KEY_INC press -> hour=0; mode=SET_MIN, minute=59, press -> minute=0, hour unchanged; exit SET_MIN -> second=0.
REQ-035 STOPWATCH, KEY_SET press, 10 ticks -> sw_centi=1; KEY_INC while running -> no change; KEY_SET then KEY_INC -> all sw_* = 0.
REQ-036 KEY_MODE and KEY_INC pulses same cycle in SET_HOUR -> mode=SET_MIN, hour unchanged; RESET asserted mid-stopwatch-run -> all outputs per REQ-026 next edge.
REQ-037 Build without WATCH_STOPWATCH_EN: 3 KEY_MODE presses -> mode sequence 1,2,0; sw_* remain 0.

Source files
------------

// File: rtl/watch_ctrl_pkg.sv
// Shared definitions for the watch controller.
//   - Mode encodings presented on the watch_ctrl 'mode' output.
//   - Wrap limits for the time-of-day and stopwatch counters.
//   - wrap_inc: increment with wrap-around to zero.
// The optional stopwatch is enabled by defining WATCH_STOPWATCH_EN.
package watch_ctrl_pkg;

  localparam logic [1:0] MODE_RUN       = 2'd0;
  localparam logic [1:0] MODE_SET_HOUR  = 2'd1;
  localparam logic [1:0] MODE_SET_MIN   = 2'd2;
  localparam logic [1:0] MODE_STOPWATCH = 2'd3;

  localparam int HOUR_LIMIT     = 24;
  localparam int MIN_LIMIT      = 60;
  localparam int SEC_LIMIT      = 60;
  localparam int CENTI_LIMIT    = 100;
  // Ticks per stopwatch hundredth of a second.
  localparam int CENTI_PRESCALE = 10;

  // Returns value+1, or 0 once value has reached limit-1.
  function automatic logic [6:0] wrap_inc(input logic [6:0] value, input int limit);
    wrap_inc = (int'(value) >= limit - 1) ? 7'd0 : value + 7'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button debouncer for one active-low key.
//   clk    : clock; state updates on the falling edge
//   rst    : synchronous, active-high reset (key treated as released)
//   tick   : one-cycle enable; the key is sampled only in tick cycles
//   key_n  : raw key level, active-low, already synchronous to clk
//   press  : one-cycle strobe when a press is accepted
//   held   : debug view of the debouncer state (1 = accepted as pressed)
// Strobe semantics: press is a single-cycle event with no acknowledge and
// no backpressure; the consumer must act in the cycle it is high.
module key_debounce #(
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic key_n,
  output logic press,
  output logic held
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

  logic [CW-1:0] cnt;
  logic          toward;
  logic          cnt_done;

  // A sample "moves toward" a state change when the key level is the
  // opposite of what has currently been accepted.
  assign toward   = held ? key_n : ~key_n;
  assign cnt_done = (cnt == CW'(DEBOUNCE_TICKS - 1));

  always_ff @(negedge clk) begin
    if (rst) begin
      held  <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (tick) begin
        if (!toward) begin
          cnt <= '0;
        end else if (cnt_done) begin
          cnt   <= '0;
          held  <= ~held;
          press <= ~held;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/watch_ctrl.sv
// Digital watch controller: time of day, set modes and optional stopwatch.
//   CLOCK          : sole clock; all state updates on its falling edge
//   RESET          : synchronous, active-high reset
//   tick_1khz      : one-cycle enable, TICKS_PER_SEC pulses per second
//   KEY_MODE/SET/INC : raw active-low push-buttons
//   mode           : 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 STOPWATCH (also the FSM state)
//   hour/minute/second : time of day
//   sw_min/sw_sec/sw_centi : stopwatch value
//   blink          : blank request for the field being edited
// Optional feature: define WATCH_STOPWATCH_EN to include STOPWATCH mode.
// Without it the mode ring is RUN->SET_HOUR->SET_MIN->RUN and sw_* are 0.
module watch_ctrl
  import watch_ctrl_pkg::*;
#(
  parameter int TICKS_PER_SEC  = 1000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       tick_1khz,
  input  logic       KEY_MODE,
  input  logic       KEY_SET,
  input  logic       KEY_INC,
  output logic [1:0] mode,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic [5:0] sw_min,
  output logic [5:0] sw_sec,
  output logic [6:0] sw_centi,
  output logic       blink
);

  localparam int MS_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  logic [MS_W-1:0] ms_cnt;
  logic            mode_p, inc_p;
  logic            unused_held_mode, unused_held_inc;

  key_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_mode (
    .clk(CLOCK), .rst(RESET), .tick(tick_1khz), .key_n(KEY_MODE),
    .press(mode_p), .held(unused_held_mode)
  );

  key_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_inc (
    .clk(CLOCK), .rst(RESET), .tick(tick_1khz), .key_n(KEY_INC),
    .press(inc_p), .held(unused_held_inc)
  );

  logic       time_runs, ms_last, sec_pulse, sec_last, min_last;
  logic [4:0] hour_inc;
  logic [5:0] minute_inc, second_inc;
  logic [1:0] mode_next;

  // Time of day only runs outside the set modes; the ms counter holds there.
  assign time_runs  = (mode == MODE_RUN) || (mode == MODE_STOPWATCH);
  assign ms_last    = (ms_cnt == MS_W'(TICKS_PER_SEC - 1));
  assign sec_pulse  = tick_1khz && time_runs && ms_last;
  assign sec_last   = (second == 6'(SEC_LIMIT - 1));
  assign min_last   = (minute == 6'(MIN_LIMIT - 1));
  assign hour_inc   = 5'(wrap_inc(7'(hour), HOUR_LIMIT));
  assign minute_inc = 6'(wrap_inc(7'(minute), MIN_LIMIT));
  assign second_inc = 6'(wrap_inc(7'(second), SEC_LIMIT));

`ifdef WATCH_STOPWATCH_EN
  assign mode_next = mode + 2'd1;
`else
  assign mode_next = (mode == MODE_SET_MIN) ? MODE_RUN : mode + 2'd1;
`endif

  assign blink = ((mode == MODE_SET_HOUR) || (mode == MODE_SET_MIN)) &&
                 (ms_cnt >= MS_W'(TICKS_PER_SEC / 2));

  always_ff @(negedge CLOCK) begin
    if (RESET) begin
      mode   <= MODE_RUN;
      hour   <= '0;
      minute <= '0;
      second <= '0;
      ms_cnt <= '0;
    end else begin
      if (tick_1khz && time_runs) begin
        ms_cnt <= ms_last ? '0 : ms_cnt + 1'b1;
      end
      if (sec_pulse) begin
        second <= second_inc;
        if (sec_last) begin
          minute <= minute_inc;
          if (min_last) hour <= hour_inc;
        end
      end
      // A mode press discards any other press strobe in the same cycle.
      if (mode_p) begin
        mode <= mode_next;
        if (mode == MODE_SET_MIN) begin
          second <= '0;
          ms_cnt <= '0;
        end
      end else if (inc_p) begin
        if (mode == MODE_SET_HOUR) hour   <= hour_inc;
        if (mode == MODE_SET_MIN)  minute <= minute_inc;
      end
    end
  end

`ifdef WATCH_STOPWATCH_EN
  logic       set_p, unused_held_set;
  logic       sw_run, sw_toggle, sw_clear, presc_last;
  logic [3:0] presc;

  key_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_set (
    .clk(CLOCK), .rst(RESET), .tick(tick_1khz), .key_n(KEY_SET),
    .press(set_p), .held(unused_held_set)
  );

  assign sw_toggle  = set_p && !mode_p && (mode == MODE_STOPWATCH);
  assign sw_clear   = inc_p && !mode_p && (mode == MODE_STOPWATCH) && !sw_run;
  assign presc_last = (presc == 4'(CENTI_PRESCALE - 1));

  // The stopwatch keeps running in every mode once started.
  always_ff @(negedge CLOCK) begin
    if (RESET) begin
      sw_run   <= 1'b0;
      presc    <= '0;
      sw_min   <= '0;
      sw_sec   <= '0;
      sw_centi <= '0;
    end else begin
      if (tick_1khz && sw_run) begin
        if (presc_last) begin
          presc    <= '0;
          sw_centi <= wrap_inc(sw_centi, CENTI_LIMIT);
          if (sw_centi == 7'(CENTI_LIMIT - 1)) begin
            sw_sec <= 6'(wrap_inc(7'(sw_sec), SEC_LIMIT));
            if (sw_sec == 6'(SEC_LIMIT - 1)) sw_min <= 6'(wrap_inc(7'(sw_min), MIN_LIMIT));
          end
        end else begin
          presc <= presc + 4'd1;
        end
      end
      if (sw_toggle) begin
        sw_run <= ~sw_run;
        // Each start measures a full prescale period before the first count.
        if (!sw_run) presc <= '0;
      end
      if (sw_clear) begin
        presc    <= '0;
        sw_min   <= '0;
        sw_sec   <= '0;
        sw_centi <= '0;
      end
    end
  end
`else
  logic unused_key_set;
  assign unused_key_set = KEY_SET;
  assign sw_min   = '0;
  assign sw_sec   = '0;
  assign sw_centi = '0;
`endif

endmodule

// File: tb/tb_watch_ctrl.sv
// Bench for watch_ctrl with TICKS_PER_SEC=10, DEBOUNCE_TICKS=3.
// The reference model keeps time as seconds-of-day and the stopwatch as
// total hundredths, and debounces keys by counting consecutive samples.
module tb_watch_ctrl;

  localparam int TPS = 10;
  localparam int DB  = 3;
`ifdef WATCH_STOPWATCH_EN
  localparam int NMODES = 4;
`else
  localparam int NMODES = 3;
`endif

  logic       CLOCK = 1'b0;
  logic       RESET, tick_1khz, KEY_MODE, KEY_SET, KEY_INC;
  logic [1:0] mode;
  logic [4:0] hour;
  logic [5:0] minute, second, sw_min, sw_sec;
  logic [6:0] sw_centi;
  logic       blink;

  always #5 CLOCK = ~CLOCK;

  watch_ctrl #(.TICKS_PER_SEC(TPS), .DEBOUNCE_TICKS(DB)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .tick_1khz(tick_1khz),
    .KEY_MODE(KEY_MODE), .KEY_SET(KEY_SET), .KEY_INC(KEY_INC),
    .mode(mode), .hour(hour), .minute(minute), .second(second),
    .sw_min(sw_min), .sw_sec(sw_sec), .sw_centi(sw_centi), .blink(blink)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_mode, m_tod, m_ms, m_swc, m_frac;
  bit m_run;
  int low_run[3], high_run[3];
  bit armed[3], pend[3];   // index 0 MODE, 1 SET, 2 INC

  task automatic model_reset();
    m_mode = 0; m_tod = 0; m_ms = 0; m_swc = 0; m_frac = 0; m_run = 0;
    for (int k = 0; k < 3; k++) begin
      low_run[k] = 0; high_run[k] = 0; armed[k] = 1; pend[k] = 0;
    end
  endtask

  task automatic model_edge();
    bit lows[3];
    int h, mi, s;
    lows[0] = !KEY_MODE; lows[1] = !KEY_SET; lows[2] = !KEY_INC;
    if (RESET) begin
      model_reset();
      return;
    end
    if (tick_1khz) begin
      if (m_mode == 0 || m_mode == 3) begin
        m_ms++;
        if (m_ms == TPS) begin m_ms = 0; m_tod = (m_tod + 1) % 86400; end
      end
      if (m_run) begin
        m_frac++;
        if (m_frac == 10) begin m_frac = 0; m_swc = (m_swc + 1) % 360000; end
      end
    end
    h = m_tod / 3600; mi = (m_tod / 60) % 60; s = m_tod % 60;
    if (pend[0]) begin
      if (m_mode == 2) begin m_ms = 0; m_tod = h * 3600 + mi * 60; end
      m_mode = (m_mode + 1) % NMODES;
    end else begin
      if (pend[2]) begin
        if (m_mode == 1) m_tod = ((h + 1) % 24) * 3600 + mi * 60 + s;
        else if (m_mode == 2) m_tod = h * 3600 + ((mi + 1) % 60) * 60 + s;
        else if (m_mode == 3 && !m_run) begin m_swc = 0; m_frac = 0; end
      end
      if (pend[1] && m_mode == 3) begin
        if (!m_run) m_frac = 0;
        m_run = !m_run;
      end
    end
    for (int k = 0; k < 3; k++) begin
      pend[k] = 0;
      if (tick_1khz) begin
        if (lows[k]) begin low_run[k]++; high_run[k] = 0; end
        else begin high_run[k]++; low_run[k] = 0; end
        if (armed[k] && low_run[k] == DB) begin pend[k] = 1; armed[k] = 0; end
        if (!armed[k] && high_run[k] == DB) armed[k] = 1;
      end
    end
  endtask

  // One clock: DUT and model update on the falling edge, checks follow the rising edge.
  task automatic step();
    @(negedge CLOCK);
    model_edge();
    @(posedge CLOCK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    chk({where, ".mode"},     32'(mode),     m_mode);
    chk({where, ".hour"},     32'(hour),     m_tod / 3600);
    chk({where, ".minute"},   32'(minute),   (m_tod / 60) % 60);
    chk({where, ".second"},   32'(second),   m_tod % 60);
    chk({where, ".sw_min"},   32'(sw_min),   m_swc / 6000);
    chk({where, ".sw_sec"},   32'(sw_sec),   (m_swc / 100) % 60);
    chk({where, ".sw_centi"}, 32'(sw_centi), m_swc % 100);
    chk({where, ".blink"},    32'(blink),    ((m_mode == 1 || m_mode == 2) && m_ms >= TPS / 2) ? 1 : 0);
  endtask

  task automatic set_keys(input logic km, input logic ks, input logic ki);
    KEY_MODE = km; KEY_SET = ks; KEY_INC = ki;
  endtask

  task automatic idle(input int n);
    set_keys(1, 1, 1);
    repeat (n) step();
  endtask

  // Hold the selected keys low long enough to be accepted, then release.
  task automatic press(input logic km, input logic ks, input logic ki);
    set_keys(km, ks, ki);
    repeat (DB + 1) step();
    idle(DB + 1);
  endtask

  task automatic press_n(input logic km, input logic ks, input logic ki, input int n);
    for (int i = 0; i < n; i++) press(km, ks, ki);
  endtask

  task automatic goto_mode(input int target);
    for (int i = 0; i < 4 && m_mode != target; i++) press(0, 1, 1);
  endtask

  int hold_left[3];
  bit lvl[3];
  int n;

  initial begin
    model_reset();
    RESET = 1; tick_1khz = 1; set_keys(1, 1, 1);
    @(posedge CLOCK);
    repeat (2) step();
    check_all("reset");
    chk("reset_mode", 32'(mode), 0);
    chk("reset_blink", 32'(blink), 0);

    // Ten ticks make one second.
    RESET = 0;
    idle(10);
    check_all("run10");
    chk("run10_second", 32'(second), 1);

    // Debounce: two low ticks are not a press, three are, holding adds nothing.
    set_keys(0, 1, 1); repeat (2) step();
    idle(DB + 1);
    chk("db_short_mode", 32'(mode), 0);
    set_keys(0, 1, 1); repeat (DB + 1) step();
    chk("db_accept_mode", 32'(mode), 1);
    repeat (20 - DB - 1) step();
    chk("db_hold_mode", 32'(mode), 1);
    idle(DB + 1);
    check_all("db_done");

    // Hour editing with wrap.
    press_n(1, 1, 0, 23);
    chk("set_hour_23", 32'(hour), 23);
    press(1, 1, 0);
    chk("set_hour_wrap", 32'(hour), 0);
    check_all("hour_wrap");
    press_n(1, 1, 0, 23);

    // MODE and INC accepted in the same cycle: only the mode step happens.
    press(0, 1, 0);
    chk("simul_mode", 32'(mode), 2);
    chk("simul_hour", 32'(hour), 23);
    check_all("simul");

    // Minute editing with wrap and no carry.
    press_n(1, 1, 0, 59);
    chk("set_min_59", 32'(minute), 59);
    press(1, 1, 0);
    chk("set_min_wrap", 32'(minute), 0);
    chk("set_min_nocarry", 32'(hour), 23);
    press_n(1, 1, 0, 59);
    press(0, 1, 1);
    chk("exit_setmin_second", 32'(second), 0);
    check_all("exit_setmin");

    // Run to 23:59:59 then one more second rolls the day.
    n = 0;
    set_keys(1, 1, 1);
    while (m_tod != 86399 && n < 1000) begin step(); n++; end
    if (n >= 1000) begin
      checks++; errors++;
      $error("FAIL wait_235959: observed %0d steps expected under 1000", n);
    end
    chk("t235959_h", 32'(hour), 23);
    chk("t235959_m", 32'(minute), 59);
    chk("t235959_s", 32'(second), 59);
    idle(TPS);
    chk("rollover_h", 32'(hour), 0);
    chk("rollover_m", 32'(minute), 0);
    chk("rollover_s", 32'(second), 0);
    check_all("rollover");

`ifdef WATCH_STOPWATCH_EN
    goto_mode(3);
    chk("sw_mode", 32'(mode), 3);
    press(1, 0, 1);
    idle(TPS - (DB + 1));
    chk("sw_first_centi", 32'(sw_centi), 1);
    press(1, 1, 0);
    check_all("sw_inc_running");
    press(1, 0, 1);
    press(1, 1, 0);
    chk("sw_clear_min", 32'(sw_min), 0);
    chk("sw_clear_sec", 32'(sw_sec), 0);
    chk("sw_clear_centi", 32'(sw_centi), 0);
    press(1, 0, 1);
    idle(25);
    press(0, 1, 1);
    idle(15);
    check_all("sw_other_mode");
    RESET = 1; set_keys(1, 0, 0);
    step();
    RESET = 0; set_keys(1, 1, 1);
    chk("sw_reset_mode", 32'(mode), 0);
    chk("sw_reset_centi", 32'(sw_centi), 0);
    chk("sw_reset_sec", 32'(sw_sec), 0);
    check_all("sw_reset");
`else
    goto_mode(0);
    press(0, 1, 1);
    chk("ring_1", 32'(mode), 1);
    press(0, 1, 1);
    chk("ring_2", 32'(mode), 2);
    press(0, 0, 1);
    chk("ring_0", 32'(mode), 0);
    chk("nosw_centi", 32'(sw_centi), 0);
    check_all("nosw");
`endif

    // Random keys, ticks and occasional resets against the model.
    for (int k = 0; k < 3; k++) begin hold_left[k] = 0; lvl[k] = 1; end
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < 3; k++) begin
        if (hold_left[k] == 0) begin
          lvl[k] = ($urandom_range(0, 2) != 0);
          hold_left[k] = $urandom_range(1, 6);
        end
        hold_left[k]--;
      end
      set_keys(lvl[0], lvl[1], lvl[2]);
      tick_1khz = ($urandom_range(0, 3) != 0);
      RESET = ($urandom_range(0, 299) == 0);
      step();
      check_all("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
